nios_systemv2_switch_ctrl: RTL
==============================

NIOS_SYSTEMV2_SWITCH_CTRL -- requirements
Module: nios_systemv2_switch_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named as follows: clk (the only clock) and reset (sampled on rising clk only).
REQ-002 Parameter WIDTH SHALL default to 8 and set the number of switch inputs.
REQ-003 Parameter DEBOUNCE_CYCLES SHALL default to 50000 and set the consecutive stable cycles needed to accept a change; legal range 2..2^20.
REQ-004 Port list (name, direction, width, meaning):
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- in_port, in, WIDTH, raw asynchronous switch levels.
- address, in, 2, Avalon-MM slave word address.
- chipselect, in, 1, slave select.
- write_n, in, 1, active-low write strobe, qualified by chipselect.
- writedata, in, 32, write data.
- readdata, out, 32, registered read data.
- irq, out, 1, active-high level interrupt.

Function
REQ-005 Each in_port bit SHALL pass through a 2-flop synchronizer (sync) before any other use.
REQ-006 Each bit SHALL have an independent debounce counter, ceil(log2(DEBOUNCE_CYCLES+1)) bits wide, and a debounced state bit (stable).
REQ-007 The counter SHALL clear to 0 on any edge where sync equals stable.
REQ-008 The counter SHALL increment by 1 on each edge where sync differs from stable.
REQ-009 On the edge where the counter would reach DEBOUNCE_CYCLES, stable SHALL take the sync value and the counter SHALL clear to 0. Net latency from an in_port change to the stable update is 2+DEBOUNCE_CYCLES edges.
REQ-010 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave stable unchanged. The counter SHALL never wrap.
REQ-011 A stable transition in either direction SHALL set the matching edgecapture bit on the same edge.
REQ-012 Register map (32-bit, unused bits read 0, writes to unused bits ignored):
- addr 0: data, RO, {0, stable}.
- addr 1: irqmask, RW, WIDTH bits.
- addr 2: edgecapture, write-1-to-clear; writing 0 to a bit leaves it unchanged.
- addr 3: raw, RO, {0, sync}.
REQ-013 A write SHALL occur on an edge with chipselect=1 and write_n=0. Writes to addr 0 and addr 3 SHALL have no effect.
REQ-014 If a W1C clear and a new edge hit the same edgecapture bit on the same edge, the set SHALL win and the bit SHALL read 1.
REQ-015 readdata SHALL update on every clk edge with the addressed register value, i.e. 1-cycle read latency with no wait states. When chipselect=0, readdata SHALL be 0.
REQ-016 irq SHALL equal |(edgecapture & irqmask), computed combinationally from registered state; no other path to irq exists.
REQ-017 Writing irqmask SHALL affect irq from the edge after the write. Edges captured while a bit is masked SHALL remain pending and SHALL assert irq once unmasked.

Reset
REQ-018 While reset=1 at a rising edge, the following SHALL go to 0: sync flops, counters, stable, irqmask, edgecapture, readdata. irq SHALL therefore be 0.
REQ-019 Reset asserted mid-debounce SHALL discard the partial count. No edgecapture bit SHALL be set by the post-reset re-evaluation until a full DEBOUNCE_CYCLES qualification completes.
REQ-020 Switches already high at reset release SHALL qualify normally after 2+DEBOUNCE_CYCLES edges and SHALL set edgecapture (rising edge from reset state 0).

Verification
REQ-021 The bench SHALL run with DEBOUNCE_CYCLES=4 and WIDTH=8, and SHALL cover the following directed scenarios:
- a) Reset, then in_port=0x01 held. Read addr 0 -> 0x00 up to edge 5, 0x01 from edge 6. edgecapture=0x01. irq=0 (mask 0).
- b) in_port bit 2 pulses high for 3 cycles. Required: data stays 0x00, edgecapture stays 0x00, irq stays 0.
- c) Write irqmask=0x01, then qualify bit 0 rising. Required: irq=1. Then write addr 2 with 0x01. Required: edgecapture=0x00 and irq=0 on the following edge.
- d) Arrange for a W1C of 0x01 to land on the same edge as a new bit-0 qualification. Required: edgecapture bit 0 reads 1 and irq stays 1.
- e) Assert reset after 2 cycles of an in_port 0x00->0xFF change. Required: all registers read 0 and irq=0. After release with 0xFF held, data=0xFF after exactly 6 edges.
- f) Writes to addr 0 and addr 3 with 0xFFFFFFFF. Required: no register change. Read of addr 1 after writing 0xFFFFFFFF returns 0x000000FF.

Source files
------------

// File: rtl/nios_systemv2_switch_ctrl_if.sv
// Avalon-MM slave bus bundle for the switch controller: word address, select,
// write strobe and data in; registered read data and level interrupt out.
interface nios_systemv2_switch_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/nios_systemv2_switch_ctrl.sv
// Debounced switch input port with edge capture and masked level interrupt,
// exposed as a four-register Avalon-MM slave (data, irqmask, edgecapture, raw).
module nios_systemv2_switch_ctrl #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            in_port,
  nios_systemv2_switch_ctrl_if.slave  bus
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_RAW  = 2'd3;

  function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
    logic [31:0] r;
    r            = '0;
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] flip;

  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic [31:0]      rd_q;
  logic [31:0]      rd_d;

  logic             wr_en;
  logic [WIDTH-1:0] wr_bits;

  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign wr_bits = bus.writedata[WIDTH-1:0];

  if (WIDTH < 32) begin : g_wdata_upper
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata[31:WIDTH];
  end

  // Debounce: a bit flips only after CNT_LAST+1 consecutive disagreeing cycles;
  // any agreeing cycle restarts the count, and qualification clears it, so it never wraps.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      flip[i]  = 1'b0;
      if (sync_p1[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          flip[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
    stable_d = stable_q ^ flip;
  end

  // Register file update; a fresh qualification beats a same-cycle W1C clear.
  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q | flip;
    if (wr_en) begin
      case (bus.address)
        ADDR_MASK: mask_d = wr_bits;
        ADDR_EDGE: edge_d = (edge_q & ~wr_bits) | flip;
        default:   ;
      endcase
    end
  end

  always_comb begin
    rd_d = '0;
    if (bus.chipselect) begin
      case (bus.address)
        ADDR_DATA: rd_d = zext(stable_q);
        ADDR_MASK: rd_d = zext(mask_q);
        ADDR_EDGE: rd_d = zext(edge_q);
        ADDR_RAW:  rd_d = zext(sync_p1);
        default:   rd_d = '0;
      endcase
    end
  end

  // Stage p0/p1: two-flop synchronizer, then debounce and register state
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      stable_q <= '0;
      mask_q   <= '0;
      edge_q   <= '0;
      rd_q     <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync_p0  <= in_port;
      sync_p1  <= sync_p0;
      stable_q <= stable_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      rd_q     <= rd_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.readdata = rd_q;
  assign bus.irq      = |(edge_q & mask_q);

endmodule
